// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath and its controller.
// Datapath side drives opcode/flags; the controller drives strobes.
interface multicycle_ctrl_if;
  logic [10:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        reg2loc;
  logic        regWrite;
  logic        AluSrc;
  logic        memtoReg;
  logic        memRead;
  logic        memWrite;
  logic [4:0]  AluControl;
  logic        illegal;
  logic [15:0] retired;

  modport slave (
    input  instr, zero, mem_ready,
    output pc_write, pc_src, ir_write,
    output reg2loc, regWrite, AluSrc,
    output memtoReg, memRead, memWrite,
    output AluControl, illegal, retired
  );

  modport master (
    output instr, zero, mem_ready,
    input  pc_write, pc_src, ir_write,
    input  reg2loc, regWrite, AluSrc,
    input  memtoReg, memRead, memWrite,
    input  AluControl, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8-subset controller: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Strobes are gated by reset so a pending access drops at once.
module multicycle_ctrl (
  input  logic clk,
  input  logic reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_LDUR, C_STUR, C_CBZ,
    C_ADD, C_SUB, C_AND, C_ORR
  } cls_e;

  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_ORR  = 5'b00001;
  localparam logic [4:0] ALU_PASS = 5'b00111;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  cls_e        dec_cls;
  cls_e        cur_cls;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  logic        pc_write, pc_src, ir_write;
  logic        reg2loc, reg_write, alu_src;
  logic        mem_to_reg, mem_read, mem_write;
  logic [4:0]  alu_ctl;

  // Opcode classifier; CBZ ignores its low 3 opcode bits.
  always_comb begin
    dec_cls = C_NONE;
    unique case (1'b1)
      (bus.instr == 11'b11111000010): dec_cls = C_LDUR;
      (bus.instr == 11'b11111000000): dec_cls = C_STUR;
      (bus.instr[10:3] == 8'b10110100): dec_cls = C_CBZ;
      (bus.instr == 11'b10001011000): dec_cls = C_ADD;
      (bus.instr == 11'b11001011000): dec_cls = C_SUB;
      (bus.instr == 11'b10001010000): dec_cls = C_AND;
      (bus.instr == 11'b10101010000): dec_cls = C_ORR;
      default: dec_cls = C_NONE;
    endcase
  end

  // Class seen this cycle: live decode in DECODE, latched after.
  assign cur_cls = (state_q == S_DECODE) ? dec_cls : cls_q;

  // Next state, strobes and retire event.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_ctl    = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        unique case (cls_q)
          C_SUB:   alu_ctl = ALU_SUB;
          C_AND:   alu_ctl = ALU_AND;
          C_ORR:   alu_ctl = ALU_ORR;
          C_CBZ:   alu_ctl = ALU_PASS;
          default: alu_ctl = ALU_ADD;
        endcase
        unique case (cls_q)
          C_CBZ: begin
            pc_src   = 1'b1;
            pc_write = bus.zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          C_LDUR, C_STUR: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LDUR);
        mem_write = (cls_q != C_LDUR);
        if (bus.mem_ready) begin
          if (cls_q == C_LDUR) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LDUR);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Register-file port and ALU-B selects hold for the whole instruction.
  always_comb begin
    reg2loc = 1'b0;
    alu_src = 1'b0;
    if (state_q != S_FETCH && state_q != S_TRAP) begin
      reg2loc = (cur_cls == C_STUR) || (cur_cls == C_CBZ);
      alu_src = (cur_cls == C_LDUR) || (cur_cls == C_STUR);
    end
  end

  // Sticky trap flag and wrapping retire counter.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = retired_q + {15'd0, retire};
  end

  // State, class, trap flag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc_write   = reset & pc_write;
  assign bus.pc_src     = reset & pc_src;
  assign bus.ir_write   = reset & ir_write;
  assign bus.reg2loc    = reset & reg2loc;
  assign bus.regWrite   = reset & reg_write;
  assign bus.AluSrc     = reset & alu_src;
  assign bus.memtoReg   = reset & mem_to_reg;
  assign bus.memRead    = reset & mem_read;
  assign bus.memWrite   = reset & mem_write;
  assign bus.AluControl = reset ? alu_ctl : ALU_ADD;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.pc_write, bus.ir_write, bus.regWrite,
            bus.memRead, bus.memWrite};
  endfunction

  // One FETCH cycle that completes immediately.
  task automatic do_fetch(input logic [10:0] op);
    @(negedge clk);
    bus.instr     = op;
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_strobes", strobes(), 5'b11010);
    chk("fetch_pc_src", bus.pc_src, 1'b0);
  endtask

  logic [10:0] rops [3];
  logic [4:0]  ralu [3];
  int          cyc;

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset         = 1'b0;
    bus.instr     = 11'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    rops = '{OP_SUB, OP_AND, OP_ORR};
    ralu = '{5'b00110, 5'b00000, 5'b00001};

    #2;
    chk("rst_strobes", strobes(), 5'b00000);
    chk("rst_alu", bus.AluControl, 5'b00010);
    chk("rst_retired", bus.retired, 16'd0);
    chk("rst_illegal", bus.illegal, 1'b0);

    // ADD with mem_ready high through DECODE (must be ignored).
    @(negedge clk);
    reset         = 1'b1;
    bus.instr     = OP_ADD;
    bus.mem_ready = 1'b1;
    #1;
    chk("add_fetch", strobes(), 5'b11010);
    @(negedge clk); #1;
    chk("add_dec_strobes", strobes(), 5'b00000);
    chk("add_dec_reg2loc", bus.reg2loc, 1'b0);
    @(negedge clk); #1;
    chk("add_exec_alu", bus.AluControl, 5'b00010);
    chk("add_exec_strobes", strobes(), 5'b00000);
    chk("add_exec_alusrc", bus.AluSrc, 1'b0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("add_wb_strobes", strobes(), 5'b00100);
    chk("add_wb_m2r", bus.memtoReg, 1'b0);
    @(negedge clk); #1;
    chk("add_retired", bus.retired, 16'd1);
    chk("add_back_fetch", strobes(), 5'b00010);

    // Remaining R-type ops.
    for (int i = 0; i < 3; i++) begin
      do_fetch(rops[i]);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk("r_dec_reg2loc", bus.reg2loc, 1'b0);
      @(negedge clk); #1;
      chk("r_exec_alu", bus.AluControl, ralu[i]);
      @(negedge clk); #1;
      chk("r_wb_strobes", strobes(), 5'b00100);
      chk("r_wb_alu", bus.AluControl, 5'b00010);
    end
    @(negedge clk); #1;
    chk("r_retired", bus.retired, 16'd4);

    // LDUR with three wait cycles in MEM: 8 cycles total.
    do_fetch(OP_LDUR);
    cyc = 1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1; cyc++;
    chk("ld_dec_strobes", strobes(), 5'b00000);
    @(negedge clk); #1; cyc++;
    chk("ld_exec_alusrc", bus.AluSrc, 1'b1);
    chk("ld_exec_alu", bus.AluControl, 5'b00010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ready = (i == 3);
      #1; cyc++;
      chk("ld_mem_strobes", strobes(), 5'b00010);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1; cyc++;
    chk("ld_wb_strobes", strobes(), 5'b00100);
    chk("ld_wb_m2r", bus.memtoReg, 1'b1);
    chk("ld_cycles", cyc, 8);
    @(negedge clk); #1;
    chk("ld_retired", bus.retired, 16'd5);

    // CBZ taken, then not taken.
    for (int z = 1; z >= 0; z--) begin
      do_fetch(OP_CBZ);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      chk("cbz_dec_reg2loc", bus.reg2loc, 1'b1);
      @(negedge clk);
      bus.zero = z[0];
      #1;
      chk("cbz_exec_pcw", bus.pc_write, z[0]);
      chk("cbz_exec_pcsrc", bus.pc_src, 1'b1);
      chk("cbz_exec_alu", bus.AluControl, 5'b00111);
      chk("cbz_exec_reg2loc", bus.reg2loc, 1'b1);
      @(negedge clk);
      bus.zero = 1'b0;
      #1;
      chk("cbz_retired", bus.retired, 16'd7 - 16'(z));
    end

    // Reset asserted in the middle of a STUR memory access.
    do_fetch(OP_STUR);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("st_dec_reg2loc", bus.reg2loc, 1'b1);
    @(negedge clk); #1;
    chk("st_exec_strobes", strobes(), 5'b00000);
    @(negedge clk); #1;
    chk("st_mem_strobes", strobes(), 5'b00001);
    #1;
    reset = 1'b0;
    #1;
    chk("st_abort_strobes", strobes(), 5'b00000);
    chk("st_abort_retired", bus.retired, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("st_rel_fetch", strobes(), 5'b00010);
    chk("st_rel_reg2loc", bus.reg2loc, 1'b0);

    // Counter wrap on a STUR retire.
    force dut.retired_q = 16'hFFFF;
    @(negedge clk);
    release dut.retired_q;
    @(negedge clk); #1;
    chk("wrap_preload", bus.retired, 16'hFFFF);
    do_fetch(OP_STUR);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("wrap_dec_strobes", strobes(), 5'b00000);
    @(negedge clk); #1;
    chk("wrap_exec_strobes", strobes(), 5'b00000);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    chk("wrap_mem_strobes", strobes(), 5'b00001);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("wrap_retired", bus.retired, 16'h0000);
    chk("wrap_fetch_strobes", strobes(), 5'b00010);

    // Illegal opcode traps and stays trapped.
    do_fetch(11'b00000000000);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("trap_dec_illegal", bus.illegal, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.mem_ready = i[0];
      #1;
      chk("trap_strobes", {strobes(), bus.illegal}, 6'b000001);
    end
    chk("trap_retired", bus.retired, 16'h0000);
    chk("trap_alu", bus.AluControl, 5'b00010);
    reset = 1'b0;
    #1;
    chk("trap_rst_illegal", bus.illegal, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
